// File: rtl/oc8051_led_ctrl_if.sv
// Register-port bundle between the 8051 SFR/port decode and the LED controller.
// The master side issues single-cycle writes and reads; the slave returns registered read data.
interface oc8051_led_ctrl_if;
  logic       i_wr_en;
  logic [2:0] i_addr;
  logic [7:0] i_wr_data;
  logic       i_rd_en;
  logic [7:0] o_rd_data;

  modport master (
    output i_wr_en,
    output i_addr,
    output i_wr_data,
    output i_rd_en,
    input  o_rd_data
  );

  modport slave (
    input  i_wr_en,
    input  i_addr,
    input  i_wr_data,
    input  i_rd_en,
    output o_rd_data
  );
endinterface

// File: rtl/oc8051_led_ctrl.sv
// Memory-mapped LED sequencer: per-LED PWM brightness with direct, blink and chase modes.
// A prescaled PWM counter runs free; a step divisor derived from PWM periods drives the modes.
module oc8051_led_ctrl #(
  parameter int PRESCALE = 4,
  parameter int NUM_LED  = 5
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  oc8051_led_ctrl_if.slave  bus,
  output logic              o_led4,
  output logic              o_led3,
  output logic              o_led2,
  output logic              o_led1,
  output logic              o_led0
);

  localparam int              PW        = $clog2(PRESCALE);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [2:0]      IDX_MAX   = 3'(NUM_LED - 1);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_STEP   = 3'd6;
  localparam logic [2:0] A_STATUS = 3'd7;

  // Encoding is architecturally visible through STATUS[5:4].
  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_DIRECT = 2'd1,
    ST_BLINK  = 2'd2,
    ST_CHASE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [7:0]         pwm_cnt_q, pwm_cnt_d;
  logic [7:0]         step_cnt_q, step_cnt_d;
  logic               phase_q, phase_d;
  logic [2:0]         idx_q, idx_d;
  logic [NUM_LED-1:0] led_q, led_d;
  logic [7:0]         rd_data_q;
  logic [2:0]         ctrl_q;
  logic [7:0]         step_q;
  logic [7:0]         duty_q [NUM_LED];

  logic               tick;
  logic               pwm_wrap;
  logic               step_pulse;
  logic               wr_ctrl;
  logic               wr_step;
  logic [NUM_LED-1:0] wr_duty;
  logic [NUM_LED-1:0] pwm_on;
  logic [NUM_LED-1:0] chase_sel;
  logic [7:0]         rd_mux;
  state_e             ctrl_state;

  assign tick       = (presc_q == PRESC_MAX);
  assign pwm_wrap   = tick && (pwm_cnt_q == 8'hFF);
  assign step_pulse = pwm_wrap && (step_cnt_q == step_q);
  assign wr_ctrl    = bus.i_wr_en && (bus.i_addr == A_CTRL);
  assign wr_step    = bus.i_wr_en && (bus.i_addr == A_STEP);

  generate
    for (genvar gi = 0; gi < NUM_LED; gi++) begin : gen_led
      assign wr_duty[gi]   = bus.i_wr_en && (bus.i_addr == 3'(gi + 1));
      assign pwm_on[gi]    = (pwm_cnt_q < duty_q[gi]);
      assign chase_sel[gi] = (idx_q == 3'(gi));
    end
  endgenerate

  // Free-running timebase; only reset ever clears it.
  always_comb begin
    presc_d   = tick ? '0 : presc_q + PW'(1);
    pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
  end

  // Mode selected by the write data of a CTRL access.
  always_comb begin
    ctrl_state = ST_OFF;
    if (bus.i_wr_data[0]) begin
      case (bus.i_wr_data[2:1])
        2'd0:    ctrl_state = ST_DIRECT;
        2'd1:    ctrl_state = ST_BLINK;
        2'd2:    ctrl_state = ST_CHASE;
        default: ctrl_state = ST_OFF;
      endcase
    end
  end

  // Next-state and LED function; a CTRL write overrides any step in the same cycle.
  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    phase_d    = phase_q;
    idx_d      = idx_q;
    led_d      = '0;

    if (pwm_wrap) begin
      step_cnt_d = step_pulse ? 8'd0 : step_cnt_q + 8'd1;
    end

    case (state_q)
      ST_DIRECT: begin
        led_d = pwm_on;
      end
      ST_BLINK: begin
        led_d = phase_q ? pwm_on : '0;
        if (step_pulse) begin
          phase_d = ~phase_q;
        end
      end
      ST_CHASE: begin
        led_d = pwm_on & chase_sel;
        if (step_pulse) begin
          idx_d = (idx_q == IDX_MAX) ? 3'd0 : idx_q + 3'd1;
        end
      end
      default: begin
        led_d = '0;
      end
    endcase

    if (wr_ctrl) begin
      state_d    = ctrl_state;
      step_cnt_d = 8'd0;
      phase_d    = 1'b0;
      idx_d      = 3'd0;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q    <= ST_OFF;
      presc_q    <= '0;
      pwm_cnt_q  <= 8'd0;
      step_cnt_q <= 8'd0;
      phase_q    <= 1'b0;
      idx_q      <= 3'd0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      pwm_cnt_q  <= pwm_cnt_d;
      step_cnt_q <= step_cnt_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      led_q      <= led_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      ctrl_q <= 3'd0;
      step_q <= 8'd0;
      for (int n = 0; n < NUM_LED; n++) begin
        duty_q[n] <= 8'd0;
      end
    end else begin
      if (wr_ctrl) begin
        ctrl_q <= bus.i_wr_data[2:0];
      end
      if (wr_step) begin
        step_q <= bus.i_wr_data;
      end
      for (int n = 0; n < NUM_LED; n++) begin
        if (wr_duty[n]) begin
          duty_q[n] <= bus.i_wr_data;
        end
      end
    end
  end

  // Read mux sees pre-edge register values, so a same-cycle write returns old data.
  always_comb begin
    rd_mux = 8'd0;
    for (int n = 0; n < NUM_LED; n++) begin
      if (bus.i_addr == 3'(n + 1)) begin
        rd_mux = duty_q[n];
      end
    end
    case (bus.i_addr)
      A_CTRL:   rd_mux = {5'd0, ctrl_q};
      A_STEP:   rd_mux = step_q;
      A_STATUS: rd_mux = {2'b00, state_q, idx_q, phase_q};
      default:  ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      rd_data_q <= 8'd0;
    end else if (bus.i_rd_en) begin
      rd_data_q <= rd_mux;
    end
  end

  assign bus.o_rd_data = rd_data_q;
  assign o_led0        = led_q[0];
  assign o_led1        = led_q[1];
  assign o_led2        = led_q[2];
  assign o_led3        = led_q[3];
  assign o_led4        = led_q[4];

endmodule

// File: tb/tb_oc8051_led_ctrl.sv
// Self-checking bench for oc8051_led_ctrl: register table, directed mode sequences and
// randomized traffic compared cycle by cycle with a time-arithmetic reference model.
module tb_oc8051_led_ctrl;
  localparam int P = 4;

  logic       clk = 1'b0;
  logic       nrst;
  logic       led4, led3, led2, led1, led0;
  logic [4:0] leds;

  oc8051_led_ctrl_if bus ();

  oc8051_led_ctrl #(.PRESCALE(P), .NUM_LED(5)) dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .bus    (bus),
    .o_led4 (led4),
    .o_led3 (led3),
    .o_led2 (led2),
    .o_led1 (led1),
    .o_led0 (led0)
  );

  assign leds = {led4, led3, led2, led1, led0};

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit bg_rd     = 1'b0;

  // Reference model: prescaler and PWM position derive from elapsed cycles since reset.
  int         t;
  int         m_reg [7];
  int         m_state, m_step_cnt, m_phase, m_idx;
  logic [4:0] m_led;
  logic [7:0] m_rd;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (t=%0d)", name, act, exp, t);
  endtask

  task automatic fail_timeout(input string name);
    total_cnt++;
    $display("FAIL %s: got timeout required event within bound", name);
  endtask

  task automatic model_reset();
    t = 0; m_state = 0; m_step_cnt = 0; m_phase = 0; m_idx = 0;
    m_led = '0; m_rd = '0;
    for (int i = 0; i < 7; i++) m_reg[i] = 0;
  endtask

  function automatic logic [7:0] rd_val(input int a);
    if (a == 7) return 8'((m_state << 4) | (m_idx << 1) | m_phase);
    return 8'(m_reg[a]);
  endfunction

  function automatic bit step_next();
    int pwm;
    pwm = (t / P) % 256;
    return ((t % P) == P - 1) && (pwm == 255) && (m_step_cnt == m_reg[6]);
  endfunction

  task automatic model_step();
    int pwm, en, mode;
    bit wrap, stp;
    logic [4:0] on;
    pwm  = (t / P) % 256;
    wrap = ((t % P) == P - 1) && (pwm == 255);
    stp  = wrap && (m_step_cnt == m_reg[6]);
    for (int n = 0; n < 5; n++) on[n] = (pwm < m_reg[1 + n]);
    case (m_state)
      1:       m_led = on;
      2:       m_led = (m_phase != 0) ? on : 5'b0;
      3:       m_led = on & (5'b1 << m_idx);
      default: m_led = 5'b0;
    endcase
    if (bus.i_rd_en) m_rd = rd_val(int'(bus.i_addr));
    if (wrap) m_step_cnt = stp ? 0 : (m_step_cnt + 1) % 256;
    if (stp && m_state == 2) m_phase = 1 - m_phase;
    if (stp && m_state == 3) m_idx = (m_idx + 1) % 5;
    if (bus.i_wr_en) begin
      if (bus.i_addr == 3'd0) begin
        m_reg[0]   = int'(bus.i_wr_data) & 7;
        en         = int'(bus.i_wr_data) & 1;
        mode       = (int'(bus.i_wr_data) >> 1) & 3;
        m_state    = (en != 0 && mode != 3) ? mode + 1 : 0;
        m_step_cnt = 0; m_phase = 0; m_idx = 0;
      end else if (bus.i_addr != 3'd7) begin
        m_reg[bus.i_addr] = int'(bus.i_wr_data);
      end
    end
    t++;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("led", int'(leds), int'(m_led));
    check("rd_data", int'(bus.o_rd_data), int'(m_rd));
  endtask

  task automatic idle_inputs();
    bus.i_wr_en = 1'b0; bus.i_wr_data = 8'h00;
    bus.i_rd_en = bg_rd; bus.i_addr = bg_rd ? 3'd7 : 3'd0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.i_wr_en = 1'b1; bus.i_addr = a; bus.i_wr_data = d; bus.i_rd_en = 1'b0;
    cyc();
    idle_inputs();
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  typedef struct {
    bit         wr;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic [2:0] raddr;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vt [15];

  initial begin
    int cnt [5];
    int n, k, toggles;
    logic prev;

    vt[0]  = '{1, 3'd0, 8'hFF, 3'd0, 8'h07};
    vt[1]  = '{1, 3'd0, 8'hF8, 3'd0, 8'h00};
    vt[2]  = '{1, 3'd1, 8'h80, 3'd1, 8'h80};
    vt[3]  = '{1, 3'd2, 8'h22, 3'd2, 8'h22};
    vt[4]  = '{1, 3'd3, 8'h33, 3'd3, 8'h33};
    vt[5]  = '{1, 3'd4, 8'h44, 3'd4, 8'h44};
    vt[6]  = '{1, 3'd5, 8'hFF, 3'd5, 8'hFF};
    vt[7]  = '{1, 3'd6, 8'h5A, 3'd6, 8'h5A};
    vt[8]  = '{1, 3'd7, 8'hFF, 3'd7, 8'h00};
    vt[9]  = '{1, 3'd0, 8'h03, 3'd7, 8'h20};
    vt[10] = '{1, 3'd0, 8'h05, 3'd7, 8'h30};
    vt[11] = '{1, 3'd0, 8'h01, 3'd7, 8'h10};
    vt[12] = '{1, 3'd0, 8'h07, 3'd7, 8'h00};
    vt[13] = '{0, 3'd0, 8'h00, 3'd0, 8'h07};
    vt[14] = '{0, 3'd0, 8'h00, 3'd1, 8'h80};

    // Reset state, then idle with STATUS polled.
    nrst = 1'b0;
    bg_rd = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_led", int'(leds), 0);
    check("reset_rd", int'(bus.o_rd_data), 0);
    nrst = 1'b1;
    bg_rd = 1'b1;
    idle_inputs();
    repeat (2000) cyc();
    check("idle_status", int'(bus.o_rd_data), 8'h00);
    check("idle_led", int'(leds), 0);

    // Register table, run well inside the first PWM period so no step can intervene.
    bg_rd = 1'b0;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      if (vt[i].wr) wr(vt[i].waddr, vt[i].wdata);
      bus.i_rd_en = 1'b1; bus.i_addr = vt[i].raddr;
      cyc();
      idle_inputs();
      check($sformatf("table%0d", i), int'(bus.o_rd_data), int'(vt[i].exp_rd));
    end

    // Same-cycle write and read returns old data; read data holds when idle.
    bus.i_wr_en = 1'b1; bus.i_addr = 3'd2; bus.i_wr_data = 8'h99; bus.i_rd_en = 1'b1;
    cyc();
    check("rw_same_old", int'(bus.o_rd_data), 8'h22);
    bus.i_wr_en = 1'b0;
    cyc();
    check("rw_same_new", int'(bus.o_rd_data), 8'h99);
    idle_inputs();
    repeat (3) cyc();
    check("rd_hold", int'(bus.o_rd_data), 8'h99);

    // Direct mode duty ratios.
    bg_rd = 1'b1;
    do_reset();
    wr(3'd1, 8'h80); wr(3'd5, 8'hFF); wr(3'd0, 8'h01);
    repeat (50) cyc();
    for (int j = 0; j < 5; j++) cnt[j] = 0;
    repeat (1024) begin cyc(); for (int j = 0; j < 5; j++) cnt[j] += int'(leds[j]); end
    check("direct_led0", cnt[0], 512);
    check("direct_led4", cnt[4], 1020);
    check("direct_led123", cnt[1] + cnt[2] + cnt[3], 0);

    // Chase with STEP=0: one LED per period.
    for (int j = 1; j <= 5; j++) wr(3'(j), 8'hFF);
    wr(3'd6, 8'h00); wr(3'd0, 8'h05);
    n = 0;
    while (m_idx != 1 && n < 3000) begin cyc(); n++; end
    if (m_idx != 1) fail_timeout("chase_wait");
    for (int j = 0; j < 5; j++) cnt[j] = 0;
    repeat (5120) begin cyc(); for (int j = 0; j < 5; j++) cnt[j] += int'(leds[j]); end
    for (int j = 0; j < 5; j++) check($sformatf("chase_led%0d", j), cnt[j], 1020);

    // Blink with STEP=1: two periods off, two on.
    wr(3'd6, 8'h01); wr(3'd0, 8'h03);
    n = 0;
    while (m_phase != 1 && n < 5000) begin cyc(); n++; end
    if (m_phase != 1) fail_timeout("blink_wait");
    for (int j = 0; j < 5; j++) cnt[j] = 0;
    toggles = 0;
    prev = bus.o_rd_data[0];
    repeat (4096) begin
      cyc();
      for (int j = 0; j < 5; j++) cnt[j] += int'(leds[j]);
      if (bus.o_rd_data[0] != prev) toggles++;
      prev = bus.o_rd_data[0];
    end
    check("blink_led0", cnt[0], 2040);
    check("blink_led3", cnt[3], 2040);
    check("blink_phase_toggles", toggles, 2);

    // CTRL write colliding with a step at idx=3: write wins, next advance a full step later.
    wr(3'd6, 8'h00); wr(3'd0, 8'h05);
    n = 0;
    while (!(m_idx == 3 && step_next()) && n < 6000) begin cyc(); n++; end
    if (!(m_idx == 3 && step_next())) fail_timeout("collide_wait");
    wr(3'd0, 8'h05);
    k = 0;
    for (int j = 1; j <= 2000; j++) begin
      cyc();
      k = j;
      if (j == 1) check("collide_status", int'(bus.o_rd_data), 8'h30);
      if (bus.o_rd_data[3:1] == 3'd1) break;
    end
    check("collide_gap", k, 1025);

    // Reserved mode is OFF.
    wr(3'd0, 8'h07);
    repeat (20) cyc();
    check("mode3_status", int'(bus.o_rd_data), 8'h00);
    check("mode3_led", int'(leds), 0);

    // Asynchronous reset mid-chase.
    wr(3'd0, 8'h05);
    n = 0;
    while (leds == 5'b0 && n < 3000) begin cyc(); n++; end
    if (leds == 5'b0) fail_timeout("async_wait");
    #2 nrst = 1'b0;
    model_reset();
    #1 check("async_led", int'(leds), 0);
    check("async_rd", int'(bus.o_rd_data), 0);
    @(negedge clk);
    nrst = 1'b1;
    bg_rd = 1'b0;
    idle_inputs();
    for (int a = 0; a < 8; a++) begin
      bus.i_rd_en = 1'b1; bus.i_addr = 3'(a);
      cyc();
      check($sformatf("post_reset_reg%0d", a), int'(bus.o_rd_data), 0);
    end
    idle_inputs();

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 25000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        bus.i_wr_en = 1'b1;
        bus.i_addr = 3'($urandom_range(0, 7));
        bus.i_wr_data = (bus.i_addr == 3'd6 && $urandom_range(0, 3) != 0) ?
                        8'($urandom_range(0, 2)) : 8'($urandom_range(0, 255));
      end else begin
        bus.i_wr_en = 1'b0;
        bus.i_addr = 3'($urandom_range(0, 7));
      end
      bus.i_rd_en = 1'($urandom_range(0, 1));
      cyc();
    end
    idle_inputs();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
